// File: rtl/rate_gen_pkg.sv
// -----------------------------------------------------------------------------
// rate_gen_pkg
// Shared definitions for the rate generator: the channel mode encoding, the
// smallest period a channel will run at, and the default top-level parameter
// values.
// -----------------------------------------------------------------------------
package rate_gen_pkg;

  // Channel behaviour after a completed period.
  typedef enum logic {
    MODE_PERIODIC = 1'b0,  // wrap and keep counting
    MODE_ONESHOT  = 1'b1   // fire once, then park with done high
  } mode_e;

  // Periods of 0 or 1 cannot produce a distinct tick/square wave, so any
  // requested value below this is stored as this value.
  localparam int MIN_PERIOD = 2;

  // Default top-level parameter values.
  localparam int DEF_N_CH       = 2;
  localparam int DEF_CNT_W      = 27;
  localparam int DEF_DEF_PERIOD = 100000000;

endpackage : rate_gen_pkg

// File: rtl/rate_gen_ch.sv
// -----------------------------------------------------------------------------
// rate_gen_ch
// One independent tick channel. It counts 0..P-1 while enabled and emits a
// one-cycle tick after every wrap, plus a square wave that is high for the
// upper half of the count. New period/mode values are staged in a shadow
// register and applied only at a clean boundary, so a running period is never
// cut short or stretched.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   run enable
//   ld_we      in   accepted load for this channel (already qualified upstream)
//   ld_period  in   requested period in clk cycles
//   ld_mode    in   requested mode (0 periodic, 1 one-shot)
//   pending    out  a staged load is waiting to be applied
//   tick       out  one-cycle pulse after each completed period
//   sq         out  square wave at the active period
//   done       out  one-shot channel has fired and stopped
// -----------------------------------------------------------------------------
module rate_gen_ch
  import rate_gen_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DEF_PERIOD = DEF_DEF_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld_we,
  input  logic [CNT_W-1:0] ld_period,
  input  logic             ld_mode,
  output logic             pending,
  output logic             tick,
  output logic             sq,
  output logic             done
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);

  // Active state
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  mode_e            r_mode;
  logic             r_done;

  // Staged load
  logic [CNT_W-1:0] r_shadow_period;
  mode_e            r_shadow_mode;
  logic             r_pending;

  // Registered outputs
  logic             r_tick;
  logic             r_sq;

  // Next-state values of the active state
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_period_next;
  mode_e            w_mode_next;
  logic             w_done_next;

  logic             w_run;
  logic             w_last;
  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_ld_period_clamped;

  assign w_ld_period_clamped = (ld_period < MIN_P) ? MIN_P : ld_period;

  // A parked one-shot channel does not count even when enabled.
  assign w_run  = en & ~r_done;
  assign w_last = (r_cnt == (r_period - CNT_W'(1)));
  assign w_wrap = w_run & w_last;

  // The staged load only takes effect at a boundary that was reached after it
  // was accepted: r_pending is the pre-edge value, so a load accepted on a
  // wrap edge waits for the next boundary.
  assign w_apply = r_pending & (w_wrap | ~en | r_done);

  always_comb begin
    w_cnt_next    = r_cnt;
    w_period_next = r_period;
    w_mode_next   = r_mode;
    w_done_next   = r_done;

    if (w_run) begin
      w_cnt_next = w_last ? '0 : (r_cnt + CNT_W'(1));
    end

    if (w_wrap && (r_mode == MODE_ONESHOT)) begin
      w_done_next = 1'b1;
    end

    // Switchover restarts the new period from zero and releases a parked
    // one-shot channel.
    if (w_apply) begin
      w_cnt_next    = '0;
      w_period_next = r_shadow_period;
      w_mode_next   = r_shadow_mode;
      w_done_next   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt           <= '0;
      r_period        <= RST_PERIOD;
      r_mode          <= MODE_PERIODIC;
      r_done          <= 1'b0;
      r_shadow_period <= RST_PERIOD;
      r_shadow_mode   <= MODE_PERIODIC;
      r_pending       <= 1'b0;
      r_tick          <= 1'b0;
      r_sq            <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_period <= w_period_next;
      r_mode   <= w_mode_next;
      r_done   <= w_done_next;
      // The wrap edge still produces its tick even when a load switches over
      // on that same edge: the outgoing period did complete.
      r_tick   <= w_wrap;
      // Square wave tracks the count that will be held in r_cnt this cycle;
      // P>>1 puts the extra cycle of an odd period in the high phase.
      r_sq     <= (w_cnt_next >= (w_period_next >> 1));

      // Accept and apply are mutually exclusive: the load port is only ready
      // while nothing is pending.
      if (ld_we) begin
        r_shadow_period <= w_ld_period_clamped;
        r_shadow_mode   <= mode_e'(ld_mode);
        r_pending       <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign pending = r_pending;
  assign tick    = r_tick;
  assign sq      = r_sq;
  assign done    = r_done;

endmodule : rate_gen_ch

// File: rtl/rate_gen.sv
// -----------------------------------------------------------------------------
// rate_gen
// Bank of N_CH independent programmable tick generators sharing one load port.
// Each channel produces a one-cycle tick per period, a square wave at that
// period and a done flag for one-shot operation.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   [N_CH]  per-channel run enable
//   ld_valid   in   load request strobe
//   ld_ch      in   [LD_W]  target channel of the load
//   ld_period  in   [CNT_W] new period in clk cycles (0 and 1 run as 2)
//   ld_mode    in   0 periodic, 1 one-shot
//   ld_ready   out  load may be accepted this cycle
//   tick       out  [N_CH]  one-cycle pulse per completed period
//   sq         out  [N_CH]  square wave at the active period
//   done       out  [N_CH]  one-shot channel has fired and stopped
// -----------------------------------------------------------------------------
module rate_gen
  import rate_gen_pkg::*;
#(
  parameter  int N_CH       = DEF_N_CH,
  parameter  int CNT_W      = DEF_CNT_W,
  parameter  int DEF_PERIOD = DEF_DEF_PERIOD,
  localparam int LD_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             ld_valid,
  input  logic [LD_W-1:0]  ld_ch,
  input  logic [CNT_W-1:0] ld_period,
  input  logic             ld_mode,
  output logic             ld_ready,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  sq,
  output logic [N_CH-1:0]  done
);

  localparam int N_SLOT = 2 ** LD_W;

  logic [N_CH-1:0]   w_pending;
  // Pending flags padded out to every encodable ld_ch value. Slots with no
  // channel behind them read as "not pending", which makes the port ready and
  // lets an out-of-range load be swallowed without touching any channel.
  logic [N_SLOT-1:0] w_pend_slot;

  genvar gi;

  generate
    for (gi = 0; gi < N_SLOT; gi++) begin : g_slot
      if (gi < N_CH) begin : g_real
        assign w_pend_slot[gi] = w_pending[gi];
      end else begin : g_empty
        assign w_pend_slot[gi] = 1'b0;
      end
    end
  endgenerate

  // Ready is forced high during reset; the channels ignore the load anyway.
  assign ld_ready = rst | ~w_pend_slot[ld_ch];

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic w_ld_we;

      assign w_ld_we = ld_valid & ~rst & (ld_ch == LD_W'(gi)) & ~w_pending[gi];

      rate_gen_ch #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .en         (en[gi]),
        .ld_we      (w_ld_we),
        .ld_period  (ld_period),
        .ld_mode    (ld_mode),
        .pending    (w_pending[gi]),
        .tick       (tick[gi]),
        .sq         (sq[gi]),
        .done       (done[gi])
      );
    end
  endgenerate

endmodule : rate_gen

// File: tb/tb_rate_gen.sv
// -----------------------------------------------------------------------------
// tb_rate_gen
// Self-checking bench for rate_gen with three channels (so that an out-of-range
// channel number exists), an 8-bit counter and a short reset period. A
// behavioural model tracks each channel as a position within its period using
// modulo arithmetic; every cycle the tick, sq, done and ld_ready outputs are
// compared against it. Directed scenarios come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_rate_gen;

  localparam int NC   = 3;
  localparam int CW   = 8;
  localparam int DEFP = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] en;
  logic          ld_valid;
  logic [1:0]    ld_ch;
  logic [CW-1:0] ld_period;
  logic          ld_mode;
  logic          ld_ready;
  logic [NC-1:0] tick;
  logic [NC-1:0] sq;
  logic [NC-1:0] done;

  int n_cmp = 0;
  int n_mis = 0;

  rate_gen #(
    .N_CH       (NC),
    .CNT_W      (CW),
    .DEF_PERIOD (DEFP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ld_valid   (ld_valid),
    .ld_ch      (ld_ch),
    .ld_period  (ld_period),
    .ld_mode    (ld_mode),
    .ld_ready   (ld_ready),
    .tick       (tick),
    .sq         (sq),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference model: position within the period, active and staged settings.
  int m_period [NC];
  int m_mode   [NC];
  int m_pos    [NC];
  int m_sp     [NC];
  int m_sm     [NC];
  bit m_pend   [NC];
  bit m_done   [NC];
  bit m_tick   [NC];
  bit m_sq     [NC];
  bit last_acc;

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_period[c] = DEFP; m_mode[c] = 0; m_pos[c] = 0;
      m_sp[c] = DEFP; m_sm[c] = 0;
      m_pend[c] = 0; m_done[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
    end
  endfunction

  function automatic void model_edge(int c, bit e, bit acc, int lp, int lm);
    bit was_pend = m_pend[c];
    bit was_done = m_done[c];
    bit wrapped  = 0;
    if (e && !was_done) begin
      m_pos[c] = (m_pos[c] + 1) % m_period[c];
      wrapped  = (m_pos[c] == 0);
    end
    m_tick[c] = wrapped;
    if (wrapped && m_mode[c] == 1) m_done[c] = 1;
    if (was_pend && (wrapped || !e || was_done)) begin
      m_pos[c] = 0; m_period[c] = m_sp[c]; m_mode[c] = m_sm[c];
      m_pend[c] = 0; m_done[c] = 0;
    end
    if (acc) begin
      m_sp[c] = (lp < 2) ? 2 : lp;
      m_sm[c] = lm;
      m_pend[c] = 1;
    end
    m_sq[c] = (m_pos[c] >= m_period[c] / 2);
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: capture which channel accepts the current load, let the edge
  // happen, advance the model, then compare away from the edge.
  task automatic cycle();
    bit [NC-1:0]   acc;
    logic [NC-1:0] e_tick, e_sq, e_done;
    logic          e_rdy;
    for (int c = 0; c < NC; c++)
      acc[c] = ld_valid && !rst && (int'(ld_ch) == c) && !m_pend[c];
    last_acc = |acc;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else for (int c = 0; c < NC; c++)
      model_edge(c, en[c], acc[c], int'(ld_period), int'(ld_mode));
    for (int c = 0; c < NC; c++) begin
      e_tick[c] = m_tick[c]; e_sq[c] = m_sq[c]; e_done[c] = m_done[c];
    end
    e_rdy = rst || (int'(ld_ch) >= NC) || !m_pend[int'(ld_ch)];
    check("tick",     8'(tick),     8'(e_tick));
    check("sq",       8'(sq),       8'(e_sq));
    check("done",     8'(done),     8'(e_done));
    check("ld_ready", 8'(ld_ready), 8'(e_rdy));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(int ch, int p, int m);
    ld_valid  = 1'b1;
    ld_ch     = 2'(ch);
    ld_period = CW'(p);
    ld_mode   = 1'(m);
    cycle();
    $display("load ch=%0d P=%0d mode=%0d rst=%0d accepted=%0d", ch, p, m, rst, last_acc);
    ld_valid  = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; en = '0; ld_valid = 1'b0; ld_ch = '0; ld_period = '0; ld_mode = 1'b0;

    // Reset state, including a load offered during reset.
    idle(2);
    load(0, 4, 0);
    idle(1);
    rst = 1'b0;
    $display("step reset released");

    // Periodic P=4 on ch0: applied while disabled, then run.
    load(0, 4, 0);
    idle(1);
    en[0] = 1'b1;
    idle(16);
    $display("step periodic P=4 ch0");

    // One-shot P=5 on ch1, then watch it stay parked.
    load(1, 5, 1);
    idle(1);
    en[1] = 1'b1;
    idle(30);
    $display("step one-shot P=5 ch1");

    // Change running ch0 from 4 to 6 mid-period; ready stays low meanwhile.
    idle(1);
    load(0, 6, 0);
    idle(20);
    $display("step switchover 4->6 ch0");

    // P=0 and P=1 both run as P=2 on ch2.
    load(2, 0, 0);
    idle(1);
    en[2] = 1'b1;
    idle(6);
    load(2, 1, 0);
    idle(8);
    $display("step degenerate periods ch2");

    // P=8 on ch0, pause 3 cycles at cnt=2.
    en[0] = 1'b0;
    load(0, 8, 0);
    idle(1);
    en[0] = 1'b1;
    idle(2);
    en[0] = 1'b0;
    idle(3);
    en[0] = 1'b1;
    idle(12);
    $display("step pause P=8 ch0");

    // Out-of-range channel: discarded, port ready.
    load(3, 3, 1);
    idle(4);
    $display("step out-of-range load");

    // Reset with a load pending: the load must never take effect.
    load(0, 3, 0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(30);
    $display("step reset with pending load");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      en        = NC'($urandom);
      rst       = ($urandom_range(0, 99) == 0);
      ld_valid  = ($urandom_range(0, 3) == 0);
      ld_ch     = 2'($urandom_range(0, 3));
      ld_period = CW'($urandom_range(0, 12));
      ld_mode   = 1'($urandom_range(0, 1));
      cycle();
      if (last_acc)
        $display("rand load ch=%0d P=%0d mode=%0d", ld_ch, ld_period, ld_mode);
    end
    rst = 1'b0; ld_valid = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_rate_gen
